// File: rtl/module_bin_a_bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter and the downstream
// two-digit 7-segment display driver.
//   - FSM state encoding for the converter
//   - digit count / nibble geometry of the packed BCD bus
//   - BCD nibble constants shared with the display driver
package module_bin_a_bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int BCD_DIGITS    = 2;
  localparam int NIB_W         = 4;
  localparam int BCD_W         = NIB_W * BCD_DIGITS;
  localparam int SAT_VALUE_DEF = 99;

  // BCD nibble constants; the display driver decodes 0..9 and treats
  // NIB_BLANK as a dark digit.
  localparam logic [NIB_W-1:0] NIB_DIGIT_MAX = 4'd9;
  localparam logic [NIB_W-1:0] NIB_ADJ_MIN   = 4'd5;
  localparam logic [NIB_W-1:0] NIB_ADJ_ADD   = 4'd3;
  localparam logic [NIB_W-1:0] NIB_BLANK     = 4'hF;

endpackage

// File: rtl/module_ajuste_bcd.sv
// Double-dabble correction cell: adds 3 to a BCD nibble that is 5 or more,
// so that the following left shift carries correctly into the next digit.
// Ports:
//   digit     4-bit BCD nibble before the shift
//   adjusted  nibble after the conditional add-3
module module_ajuste_bcd
  import module_bin_a_bcd_pkg::*;
(
  input  logic [NIB_W-1:0] digit,
  output logic [NIB_W-1:0] adjusted
);

  assign adjusted = (digit >= NIB_ADJ_MIN) ? (digit + NIB_ADJ_ADD) : digit;

endmodule

// File: rtl/module_bin_a_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Inputs above SAT_VALUE are clamped and flagged on ovf_o. The last result
// is held on bcd_o between conversions for the display driver.
// Ports:
//   clk_i    system clock
//   rst_i    synchronous active-high reset
//   bin_i    binary value, sampled on an accepted handshake
//   valid_i  request; accepted when valid_i & ready_o at a rising edge
//   ready_o  high only in IDLE
//   bcd_o    registered result {tens, units}
//   done_o   one-cycle pulse when bcd_o updates
//   ovf_o    registered; 1 if the last accepted input was clamped
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for a request, ready_o high
// ST_SHIFT | one add-3/shift step per clock, BIN_WIDTH steps in total
// ST_DONE  | publish scratch to bcd_o, pulse done_o, return to IDLE
module module_bin_a_bcd
  import module_bin_a_bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 7,
  parameter int SAT_VALUE = SAT_VALUE_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [BIN_WIDTH-1:0] bin_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [BCD_W-1:0]     bcd_o,
  output logic                 done_o,
  output logic                 ovf_o
);

  localparam int CNT_W   = $clog2(BIN_WIDTH + 1);
  localparam int SH_W    = BCD_W + BIN_WIDTH;
  // For narrow inputs the saturation point can exceed the input range;
  // clip it so the comparison stays in BIN_WIDTH bits.
  localparam int MAX_BIN = (1 << BIN_WIDTH) - 1;
  localparam int SAT_EFF = (SAT_VALUE < MAX_BIN) ? SAT_VALUE : MAX_BIN;
  localparam logic [BIN_WIDTH-1:0] SAT_BIN = BIN_WIDTH'(SAT_EFF);

  state_t                 state_q, state_d;
  logic [BIN_WIDTH-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]       scratch_q, scratch_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pend_ovf_q, pend_ovf_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d;
  logic                   ovf_q, ovf_d;
  logic                   done_q, done_d;

  logic [BCD_W-1:0]       adj;
  logic [SH_W-1:0]        shifted;
  logic                   over_sat;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
    module_ajuste_bcd u_ajuste (
      .digit    (scratch_q[g*NIB_W +: NIB_W]),
      .adjusted (adj[g*NIB_W +: NIB_W])
    );
  end

  // Saturation keeps the corrected tens digit below 8, so the bit shifted
  // out of the top of the scratch register is always zero.
  assign shifted  = {adj, bin_q} << 1;
  assign over_sat = (bin_i > SAT_BIN);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      bin_q      <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      pend_ovf_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      pend_ovf_q <= pend_ovf_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    pend_ovf_d = pend_ovf_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          bin_d      = over_sat ? SAT_BIN : bin_i;
          pend_ovf_d = over_sat;
          scratch_d  = '0;
          cnt_d      = CNT_W'(BIN_WIDTH);
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        scratch_d = shifted[BIN_WIDTH +: BCD_W];
        bin_d     = shifted[BIN_WIDTH-1:0];
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bcd_d   = scratch_q;
        ovf_d   = pend_ovf_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ready_o = (state_q == ST_IDLE);
  assign bcd_o   = bcd_q;
  assign done_o  = done_q;
  assign ovf_o   = ovf_q;

endmodule
